ce_rw_mem_responder: RTL and testbench

//  Responder (slave) end of the ce/wr/rd chip-enable memory interface; the

---
 rtl/ce_rw_mem_responder_pkg.sv | 32 +++
 rtl/ce_rw_mem_responder_if.sv | 24 ++
 rtl/ce_rw_mem_responder_sat_counter.sv | 25 ++
 rtl/ce_rw_mem_responder.sv | 99 +++++++++
 tb/tb_ce_rw_mem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ce_rw_mem_responder_pkg.sv
// Shared op encoding and strobe decode for the ce/wr/rd chip-enable memory interface.
// Initiator, responder and checker all use the same decode so that they agree on it.
package ce_rw_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WR    = 2'd1,
    OP_RD    = 2'd2,
    OP_WR_RD = 2'd3
  } ce_rw_op_e;

  function automatic ce_rw_op_e ce_rw_decode(input logic ce, input logic wr, input logic rd);
    ce_rw_op_e op;
    if (!ce) begin
      op = OP_NONE;
    end else begin
      case ({wr, rd})
        2'b10:   op = OP_WR;
        2'b01:   op = OP_RD;
        2'b11:   op = OP_WR_RD;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

  // A strobe without chip enable is a protocol violation, not an access.
  function automatic logic ce_rw_strobe_err(input logic ce, input logic wr, input logic rd);
    return (wr | rd) & ~ce;
  endfunction

endpackage

// File: rtl/ce_rw_mem_responder_if.sv
// Bus bundle for the ce/wr/rd memory interface. The initiator drives the
// request fields, and the responder returns the read data together with a valid pulse.
interface ce_rw_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ce;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output ce, wr, rd, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  ce, wr, rd, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/ce_rw_mem_responder_sat_counter.sv
// Up-counter that stops at its all-ones value instead of wrapping.
module ce_rw_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1'b1);

  logic [W-1:0] cnt_r;

  // Count register: reset clears it, and it holds once it reaches CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign cnt = cnt_r;
endmodule

// File: rtl/ce_rw_mem_responder.sv
// Responder end of the ce/wr/rd interface: a flop-based register file that
// returns read data one cycle after the read, with access counters and a sticky error flag.
module ce_rw_mem_responder
  import ce_rw_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ce_rw_mem_responder_if.slave  bus,
  output logic                  err,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic [CNT_W-1:0]      rd_cnt
);
  localparam int DEPTH = 32'sd1 << ADDR_W;

  ce_rw_op_e         op_s;
  logic              do_wr_s;
  logic              do_rd_s;
  logic              strobe_err_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic              err_r;

  // Decode the current request into write and read enables.
  always_comb begin
    op_s         = ce_rw_decode(bus.ce, bus.wr, bus.rd);
    strobe_err_s = ce_rw_strobe_err(bus.ce, bus.wr, bus.rd);
    do_wr_s      = 1'b0;
    do_rd_s      = 1'b0;
    case (op_s)
      OP_WR:    do_wr_s = 1'b1;
      OP_RD:    do_rd_s = 1'b1;
      OP_WR_RD: begin
        do_wr_s = 1'b1;
        do_rd_s = 1'b1;
      end
      default: begin
        do_wr_s = 1'b0;
        do_rd_s = 1'b0;
      end
    endcase
  end

  // Memory array; the whole array is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (do_wr_s) begin
      mem_r[bus.addr] <= bus.wdata;
    end
  end

  // Read port. A simultaneous write forwards its own data (write-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= {DATA_W{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= do_rd_s;
      if (do_rd_s) begin
        rdata_r <= do_wr_s ? bus.wdata : mem_r[bus.addr];
      end
    end
  end

  // Sticky protocol error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (strobe_err_s) begin
      err_r <= 1'b1;
    end
  end

  ce_rw_sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (do_wr_s),
    .cnt (wr_cnt)
  );

  ce_rw_sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (do_rd_s),
    .cnt (rd_cnt)
  );

  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;
  assign err        = err_r;
endmodule

// File: tb/tb_ce_rw_mem_responder.sv
// Directed bench for ce_rw_mem_responder: a CNT_W=8 instance for the main
// checks, and a CNT_W=3 instance for counter saturation and back-to-back reads.
module tb_ce_rw_mem_responder;
  logic       clk;
  logic       rst;
  logic       err;
  logic [7:0] wr_cnt;
  logic [7:0] rd_cnt;
  logic       err_s;
  logic [2:0] wr_cnt_s;
  logic [2:0] rd_cnt_s;

  int n_tests;
  int n_fail;

  ce_rw_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();
  ce_rw_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) bus_s ();

  ce_rw_mem_responder #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .err    (err),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );

  ce_rw_mem_responder #(.ADDR_W(4), .DATA_W(8), .CNT_W(3)) dut_sat (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_s),
    .err    (err_s),
    .wr_cnt (wr_cnt_s),
    .rd_cnt (rd_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic r,
                       input logic [3:0] a, input logic [7:0] d);
    bus.ce = c; bus.wr = w; bus.rd = r; bus.addr = a; bus.wdata = d;
  endtask

  task automatic drive_s(input logic c, input logic w, input logic r,
                         input logic [3:0] a, input logic [7:0] d);
    bus_s.ce = c; bus_s.wr = w; bus_s.rd = r; bus_s.addr = a; bus_s.wdata = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive_s(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

    // 1: reset state, then every word reads as zero
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'(i), 8'h00);
      tick();
      chk("rst_mem_rvalid", 32'(bus.rvalid), 32'h1);
      chk("rst_mem_rdata", 32'(bus.rdata), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("rvalid_drop", 32'(bus.rvalid), 32'h0);
    chk("rd_cnt_16", 32'(rd_cnt), 32'd16);

    // 2: write presented in the reset-release cycle, then read back
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
    tick();
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("t2_rd_cnt0", 32'(rd_cnt), 32'd0);
    chk("t2_no_rvalid", 32'(bus.rvalid), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    tick();
    chk("t2_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t2_rdata", 32'(bus.rdata), 32'hA5);
    chk("t2_wr_cnt1", 32'(wr_cnt), 32'd1);
    chk("t2_rd_cnt1", 32'(rd_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("t2_rvalid_low", 32'(bus.rvalid), 32'h0);
    chk("t2_rdata_hold", 32'(bus.rdata), 32'hA5);

    // 3: write-first wr+rd, read-after-write, neighbour words intact
    drive(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C);
    tick();
    chk("t3_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t3_rdata", 32'(bus.rdata), 32'h3C);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
    tick();
    chk("t3_mem5", 32'(bus.rdata), 32'h3C);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h42);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd2, 8'h00);
    tick();
    chk("t3_raw", 32'(bus.rdata), 32'h42);
    drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    tick();
    chk("t3_mem3", 32'(bus.rdata), 32'hA5);
    chk("t3_wr_cnt3", 32'(wr_cnt), 32'd3);
    chk("t3_rd_cnt5", 32'(rd_cnt), 32'd5);

    // 4: strobe without ce sets err, has no other effect, and err is sticky
    drive(1'b0, 1'b1, 1'b0, 4'd2, 8'hFF);
    tick();
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("t4_rvalid", 32'(bus.rvalid), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 4'd2, 8'h00);
    tick();
    chk("t4_mem2", 32'(bus.rdata), 32'h42);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b1, 1'b0, 4'd9, 8'(i + 16));
      else            drive(1'b1, 1'b0, 1'b1, 4'd9, 8'h00);
      tick();
      chk("t4_err_sticky", 32'(err), 32'h1);
      if (i % 2 == 1) chk("t4_rdata9", 32'(bus.rdata), 32'(i + 15));
    end
    chk("t4_wr_cnt8", 32'(wr_cnt), 32'd8);
    chk("t4_rd_cnt11", 32'(rd_cnt), 32'd11);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 8'h00);
    tick();
    chk("t4_rd_no_ce", 32'(bus.rvalid), 32'h0);
    chk("t4_rd_cnt_hold", 32'(rd_cnt), 32'd11);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("t4_err_clear", 32'(err), 32'h0);

    // 5: reset in the cycle after an accepted read wins
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd1, 8'h77);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd1, 8'h00);
    tick();
    chk("t5_rdata", 32'(bus.rdata), 32'h77);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_rvalid_rst", 32'(bus.rvalid), 32'h0);
    chk("t5_rdata_rst", 32'(bus.rdata), 32'h0);
    chk("t5_rd_cnt_rst", 32'(rd_cnt), 32'd0);
    chk("t5_wr_cnt_rst", 32'(wr_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("t5_dropped", 32'(bus.rvalid), 32'h0);
    chk("t5_rd_cnt_after", 32'(rd_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd1, 8'h00);
    tick();
    chk("t5_mem_cleared", 32'(bus.rdata), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

    // 6: 3-bit counter saturation and back-to-back reads on the small instance
    for (int i = 0; i < 10; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 4'(i), 8'(8'h10 + i));
      tick();
      chk("t6_wr_cnt_sat", 32'(wr_cnt_s), (i < 7) ? 32'(i + 1) : 32'd7);
    end
    for (int i = 0; i < 4; i++) begin
      drive_s(1'b1, 1'b0, 1'b1, 4'(i), 8'h00);
      tick();
      chk("t6_b2b_rvalid", 32'(bus_s.rvalid), 32'h1);
      chk("t6_b2b_rdata", 32'(bus_s.rdata), 32'(8'h10 + i));
    end
    drive_s(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("t6_rvalid_end", 32'(bus_s.rvalid), 32'h0);
    chk("t6_rd_cnt", 32'(rd_cnt_s), 32'd4);
    chk("t6_err", 32'(err_s), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
